ysyx_22050612_regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port between two writeback sources: EXU (ALU/CSR results) and LSU (load data). Tracks per-register pending writes in a scoreboard so IDU can stall on RAW and WAW hazards. Sits between EXU/LSU writeback and the register file write port. The register file read path is untouched.

---
 rtl/ysyx_22050612_regfile_wb_arbiter_if.sv | 32 +++
 rtl/ysyx_22050612_regfile_wb_arbiter.sv | 56 +++++
 tb/tb_ysyx_22050612_regfile_wb_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050612_regfile_wb_arbiter_if.sv
// ysyx_22050612_regfile_wb_arbiter_if: issue, hazard query, writeback and register file write port bundle
interface ysyx_22050612_regfile_wb_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
);
  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_rd;
  logic                  issue_ready;
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  exu_valid;
  logic [ADDR_WIDTH-1:0] exu_rd;
  logic [DATA_WIDTH-1:0] exu_data;
  logic                  exu_ready;
  logic                  lsu_valid;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;
  logic                  lsu_ready;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  modport master (
    output issue_valid, issue_rd, rs1, rs2, exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data,
    input  issue_ready, rs1_busy, rs2_busy, exu_ready, lsu_ready, rf_wen, rf_waddr, rf_wdata
  );
  modport slave (
    input  issue_valid, issue_rd, rs1, rs2, exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data,
    output issue_ready, rs1_busy, rs2_busy, exu_ready, lsu_ready, rf_wen, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/ysyx_22050612_regfile_wb_arbiter.sv
// ysyx_22050612_regfile_wb_arbiter: round-robin EXU/LSU writeback arbiter with a per-register pending-write scoreboard
module ysyx_22050612_regfile_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input logic clk,
  input logic rst,
  ysyx_22050612_regfile_wb_arbiter_if.slave bus
);
  localparam int N = 2 ** ADDR_WIDTH;
  logic [N-1:0]          busy_q, busy_d;
  logic                  last_lsu_q;
  logic                  rf_wen_q;
  logic [ADDR_WIDTH-1:0] rf_waddr_q;
  logic [DATA_WIDTH-1:0] rf_wdata_q;
  logic                  grant_exu, grant_lsu, wb;
  logic [ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  // LSU wins a tie unless it took the previous grant
  assign grant_lsu = bus.lsu_valid && (!bus.exu_valid || !last_lsu_q);
  assign grant_exu = bus.exu_valid && !grant_lsu;
  assign wb        = grant_exu || grant_lsu;
  assign wb_rd     = grant_lsu ? bus.lsu_rd : bus.exu_rd;
  assign wb_data   = grant_lsu ? bus.lsu_data : bus.exu_data;
  assign bus.exu_ready   = grant_exu;
  assign bus.lsu_ready   = grant_lsu;
  assign bus.issue_ready = (bus.issue_rd == '0) || !busy_q[bus.issue_rd];
  assign bus.rs1_busy    = (bus.rs1 != '0) && busy_q[bus.rs1];
  assign bus.rs2_busy    = (bus.rs2 != '0) && busy_q[bus.rs2];
  assign bus.rf_wen      = rf_wen_q;
  assign bus.rf_waddr    = rf_waddr_q;
  assign bus.rf_wdata    = rf_wdata_q;
  always_comb begin
    busy_d = busy_q;
    if (wb) busy_d[wb_rd] = 1'b0;
    if (bus.issue_valid && bus.issue_ready) busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      last_lsu_q <= 1'b0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      busy_q   <= busy_d;
      rf_wen_q <= wb && (wb_rd != '0);
      if (wb) last_lsu_q <= grant_lsu;
      if (wb && (wb_rd != '0)) begin
        rf_waddr_q <= wb_rd;
        rf_wdata_q <= wb_data;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_22050612_regfile_wb_arbiter.sv
// tb_ysyx_22050612_regfile_wb_arbiter: scoreboard bench with a reference arbiter/busy model
module tb_ysyx_22050612_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  ysyx_22050612_regfile_wb_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) bus ();
  ysyx_22050612_regfile_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic        wen;
    logic [4:0]  a;
    logic [63:0] d;
  } exp_t;
  exp_t q[$];
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] m_busy = '0;
  logic m_last_lsu = 1'b0;
  logic g_e, g_l, g_i;
  logic e_ge, e_gl;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic iv, input logic [4:0] ird, input logic ev, input logic [4:0] erd,
                       input logic [63:0] ed, input logic lv, input logic [4:0] lrd, input logic [63:0] ld);
    bus.issue_valid = iv; bus.issue_rd = ird;
    bus.exu_valid = ev; bus.exu_rd = erd; bus.exu_data = ed;
    bus.lsu_valid = lv; bus.lsu_rd = lrd; bus.lsu_data = ld;
  endtask
  task automatic cyc();
    logic ir, r1, r2;
    logic [4:0] rd;
    exp_t e, o;
    #1;
    ir = (bus.issue_rd == 0) || !m_busy[bus.issue_rd];
    r1 = (bus.rs1 != 0) && m_busy[bus.rs1];
    r2 = (bus.rs2 != 0) && m_busy[bus.rs2];
    e_gl = bus.lsu_valid && (!bus.exu_valid || !m_last_lsu);
    e_ge = bus.exu_valid && !e_gl;
    g_e = bus.exu_ready; g_l = bus.lsu_ready; g_i = bus.issue_ready;
    rd = e_gl ? bus.lsu_rd : bus.exu_rd;
    if (!rst) begin
      chk("issue_ready", bus.issue_ready, ir);
      chk("rs1_busy", bus.rs1_busy, r1);
      chk("rs2_busy", bus.rs2_busy, r2);
      chk("exu_ready", bus.exu_ready, e_ge);
      chk("lsu_ready", bus.lsu_ready, e_gl);
    end
    e.wen = !rst && (e_ge || e_gl) && (rd != 0);
    e.a = rd;
    e.d = e_gl ? bus.lsu_data : bus.exu_data;
    q.push_back(e);
    if (rst) begin
      m_busy = '0; m_last_lsu = 1'b0;
    end else begin
      if (e_ge || e_gl) begin
        m_busy[rd] = 1'b0; m_last_lsu = e_gl;
      end
      if (bus.issue_valid && ir && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
    o = q.pop_front();
    chk("rf_wen", bus.rf_wen, o.wen);
    if (o.wen) begin
      chk("rf_waddr", bus.rf_waddr, o.a);
      chk("rf_wdata", bus.rf_wdata, o.d);
    end
  endtask
  initial begin
    int ei, li;
    bus.rs1 = 5; bus.rs2 = 0;
    drive(0, 0, 1, 5, 64'h55, 0, 0, 0);
    cyc(); cyc();
    rst = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("rst_rs1_busy", bus.rs1_busy, 0);
    chk("rst_waddr", bus.rf_waddr, 0);
    chk("rst_wdata", bus.rf_wdata, 0);
    // single EXU write
    drive(1, 3, 0, 0, 0, 0, 0, 0);
    cyc();
    bus.rs1 = 3;
    drive(0, 0, 1, 3, 64'h1234, 0, 0, 0);
    cyc();
    chk("exu_single_ready", g_e, 1);
    chk("exu_single_wen", bus.rf_wen, 1);
    chk("exu_single_data", bus.rf_wdata, 64'h1234);
    chk("rs1_cleared", bus.rs1_busy, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    // contention
    ei = 0; li = 0;
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 5'(1 + ei), 64'(100 + ei), 1, 5'(8 + li), 64'(200 + li));
      cyc();
      chk("alt_lsu", g_l, (k % 2 == 0) ? 1 : 0);
      chk("alt_exu", g_e, (k % 2 == 1) ? 1 : 0);
      if (g_e) ei++;
      if (g_l) li++;
    end
    // WAW stall on rd 7
    bus.rs1 = 7; bus.rs2 = 7;
    drive(1, 7, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("waw_first", g_i, 1);
    cyc();
    chk("waw_stall", g_i, 0);
    drive(1, 7, 1, 7, 64'hABCD, 0, 0, 0);
    cyc();
    chk("waw_stall_wb", g_i, 0);
    drive(1, 7, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("waw_release", g_i, 1);
    drive(0, 0, 0, 0, 0, 1, 7, 64'h77);
    cyc();
    // x0
    bus.rs1 = 0; bus.rs2 = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("x0_issue", g_i, 1);
    drive(0, 0, 0, 0, 0, 1, 0, 64'hDEAD);
    cyc();
    chk("x0_lsu_ready", g_l, 1);
    chk("x0_wen", bus.rf_wen, 0);
    chk("x0_rs1", bus.rs1_busy, 0);
    // mid-operation reset
    bus.rs1 = 4;
    drive(1, 4, 0, 0, 0, 0, 0, 0);
    cyc();
    rst = 1;
    drive(0, 0, 0, 0, 0, 1, 4, 64'h4444);
    cyc();
    rst = 0;
    chk("mid_rst_wen", bus.rf_wen, 0);
    drive(0, 0, 1, 2, 64'h22, 1, 9, 64'h99);
    cyc();
    chk("mid_rst_busy4", bus.rs1_busy, 0);
    chk("mid_rst_tie", g_l, 1);
    drive(0, 0, 1, 2, 64'h22, 0, 0, 0);
    cyc();
    // random traffic against the model
    for (int k = 0; k < 300; k++) begin
      bus.rs1 = 5'($urandom_range(0, 31)); bus.rs2 = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            64'($urandom), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 64'($urandom));
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
